// File: rtl/core_ctrl_pkg.sv
// Shared types and constants for the chunked core control FSM.
`timescale 1ns/1ps
package core_ctrl_pkg;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_STORE = 3'd1,
        ST_TRANS = 3'd2,
        ST_PROC  = 3'd3,
        ST_ERROR = 3'd4
    } ctrl_state_e;

    // One-hot data location codes driven on ctrl_data_contition.
    localparam logic [2:0] COND_NONE  = 3'b000;
    localparam logic [2:0] COND_INPUT = 3'b100;
    localparam logic [2:0] COND_MEM   = 3'b010;
    localparam logic [2:0] COND_REG   = 3'b001;

endpackage

// File: rtl/core_ctrl_watchdog.sv
// Handshake watchdog: counts cycles spent waiting in one state and flags the
// cycle in which the count would reach its all-ones limit.
`timescale 1ns/1ps
module core_ctrl_watchdog #(
    parameter int TO_W = 8
) (
    input  logic ctrl_clk,
    input  logic ctrl_reset,
    input  logic clear,
    input  logic enable,
    output logic expired
);

    localparam logic [TO_W-1:0] LIMIT = {TO_W{1'b1}};

    logic [TO_W-1:0] count_q, count_d;

    // Clearing wins over counting so every new state starts a fresh window.
    always_comb begin
        count_d = count_q;
        if (clear) begin
            count_d = '0;
        end else if (enable) begin
            count_d = count_q + TO_W'(1);
        end
    end

    always_ff @(posedge ctrl_clk or posedge ctrl_reset) begin
        if (ctrl_reset) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

    assign expired = enable && (count_q == LIMIT - TO_W'(1));

endmodule

// File: rtl/core_chunk_control.sv
// Instruction sequencer splitting a payload into CHUNK-word transfer/process
// passes. Define CORE_CTRL_WATCHDOG_EN to trap stalled handshakes in ERROR.
`timescale 1ns/1ps
module core_chunk_control
    import core_ctrl_pkg::*;
#(
    parameter int LEN_W = 6,
    parameter int OP_W  = 3,
    parameter int CHUNK = 8,
    parameter int TO_W  = 8
) (
    input  logic             ctrl_clk,
    input  logic             ctrl_reset,
    input  logic             ctrl_valid_inst,
    input  logic             ctrl_valid_data,
    input  logic [OP_W-1:0]  ctrl_instruction,
    input  logic [LEN_W-1:0] ctrl_data_in_size,
    output logic             ctrl_ready,
    output logic             ctrl_done,
    output logic             ctrl_err,
    input  logic             ctrl_err_clr,
    output logic [2:0]       ctrl_data_contition,
    output logic [LEN_W-1:0] mc_data_length,
    input  logic             mc_done,
    output logic             procc_start,
    output logic [OP_W-1:0]  procc_op,
    input  logic             procc_done
);

    localparam logic [LEN_W-1:0] CHUNK_L = LEN_W'(CHUNK);

    function automatic logic [LEN_W-1:0] chunkLen(input logic [LEN_W-1:0] remaining);
        return (remaining > CHUNK_L) ? CHUNK_L : remaining;
    endfunction

    ctrl_state_e      state_q, state_d;
    logic [LEN_W-1:0] rem_q, rem_d;
    logic [LEN_W-1:0] len_q, len_d;
    logic [2:0]       cond_q, cond_d;
    logic [OP_W-1:0]  op_q, op_d;
    logic             start_q, start_d;
    logic             done_q, done_d;
    logic             err_q, err_d;
    logic             wdExpired;

`ifdef CORE_CTRL_WATCHDOG_EN
    logic wdClear;
    logic wdEnable;

    assign wdClear  = (state_d != state_q);
    assign wdEnable = (state_q == ST_STORE) || (state_q == ST_TRANS) || (state_q == ST_PROC);

    core_ctrl_watchdog #(
        .TO_W(TO_W)
    ) u_watchdog (
        .ctrl_clk  (ctrl_clk),
        .ctrl_reset(ctrl_reset),
        .clear     (wdClear),
        .enable    (wdEnable),
        .expired   (wdExpired)
    );
`else
    assign wdExpired = 1'b0;
`endif

    // Next-state and registered-output logic; the awaited handshake always
    // takes priority over watchdog expiry in the same cycle.
    always_comb begin
        state_d = state_q;
        rem_d   = rem_q;
        len_d   = len_q;
        cond_d  = cond_q;
        op_d    = op_q;
        start_d = start_q;
        done_d  = 1'b0;
        err_d   = err_q;
        case (state_q)
            ST_IDLE: begin
                if (ctrl_valid_inst && ctrl_valid_data) begin
                    op_d  = ctrl_instruction;
                    rem_d = ctrl_data_in_size;
                    if (ctrl_data_in_size == '0) begin
                        done_d = 1'b1;
                    end else begin
                        state_d = ST_STORE;
                        cond_d  = COND_INPUT;
                        len_d   = ctrl_data_in_size;
                    end
                end
            end
            ST_STORE: begin
                if (mc_done) begin
                    state_d = ST_TRANS;
                    cond_d  = COND_MEM;
                    len_d   = chunkLen(rem_q);
                end else if (wdExpired) begin
                    state_d = ST_ERROR;
                end
            end
            ST_TRANS: begin
                if (mc_done) begin
                    state_d = ST_PROC;
                    cond_d  = COND_REG;
                    start_d = 1'b1;
                    rem_d   = (rem_q >= len_q) ? (rem_q - len_q) : '0;
                end else if (wdExpired) begin
                    state_d = ST_ERROR;
                end
            end
            ST_PROC: begin
                if (procc_done) begin
                    start_d = 1'b0;
                    if (rem_q == '0) begin
                        state_d = ST_IDLE;
                        cond_d  = COND_NONE;
                        done_d  = 1'b1;
                    end else begin
                        state_d = ST_TRANS;
                        cond_d  = COND_MEM;
                        len_d   = chunkLen(rem_q);
                    end
                end else if (wdExpired) begin
                    state_d = ST_ERROR;
                end
            end
            ST_ERROR: begin
                if (ctrl_err_clr) begin
                    state_d = ST_IDLE;
                    err_d   = 1'b0;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
        if (state_d == ST_ERROR && state_q != ST_ERROR) begin
            cond_d  = COND_NONE;
            start_d = 1'b0;
            err_d   = 1'b1;
        end
    end

    always_ff @(posedge ctrl_clk or posedge ctrl_reset) begin
        if (ctrl_reset) begin
            state_q <= ST_IDLE;
            rem_q   <= '0;
            len_q   <= '0;
            cond_q  <= COND_NONE;
            op_q    <= '0;
            start_q <= 1'b0;
            done_q  <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            rem_q   <= rem_d;
            len_q   <= len_d;
            cond_q  <= cond_d;
            op_q    <= op_d;
            start_q <= start_d;
            done_q  <= done_d;
            err_q   <= err_d;
        end
    end

    assign ctrl_ready          = (state_q == ST_IDLE) && !ctrl_reset;
    assign ctrl_done           = done_q;
    assign ctrl_err            = err_q;
    assign ctrl_data_contition = cond_q;
    assign mc_data_length      = len_q;
    assign procc_start         = start_q;
    assign procc_op            = op_q;

endmodule

// File: tb/tb_core_chunk_control.sv
// Directed self-checking bench for core_chunk_control with CHUNK=8, TO_W=4.
`timescale 1ns/1ps
module tb_core_chunk_control;

    logic       ctrl_clk;
    logic       ctrl_reset;
    logic       ctrl_valid_inst;
    logic       ctrl_valid_data;
    logic [2:0] ctrl_instruction;
    logic [5:0] ctrl_data_in_size;
    logic       ctrl_ready;
    logic       ctrl_done;
    logic       ctrl_err;
    logic       ctrl_err_clr;
    logic [2:0] ctrl_data_contition;
    logic [5:0] mc_data_length;
    logic       mc_done;
    logic       procc_start;
    logic [2:0] procc_op;
    logic       procc_done;

    int errors = 0;
    int checks = 0;

    // Observed bundle: ready, done, err, start, contition[2:0], length[5:0].
    logic [12:0] obs;
    logic [12:0] exp;
    assign obs = {ctrl_ready, ctrl_done, ctrl_err, procc_start, ctrl_data_contition, mc_data_length};

    core_chunk_control #(
        .LEN_W(6),
        .OP_W (3),
        .CHUNK(8),
        .TO_W (4)
    ) dut (
        .ctrl_clk           (ctrl_clk),
        .ctrl_reset         (ctrl_reset),
        .ctrl_valid_inst    (ctrl_valid_inst),
        .ctrl_valid_data    (ctrl_valid_data),
        .ctrl_instruction   (ctrl_instruction),
        .ctrl_data_in_size  (ctrl_data_in_size),
        .ctrl_ready         (ctrl_ready),
        .ctrl_done          (ctrl_done),
        .ctrl_err           (ctrl_err),
        .ctrl_err_clr       (ctrl_err_clr),
        .ctrl_data_contition(ctrl_data_contition),
        .mc_data_length     (mc_data_length),
        .mc_done            (mc_done),
        .procc_start        (procc_start),
        .procc_op           (procc_op),
        .procc_done         (procc_done)
    );

    initial ctrl_clk = 1'b0;
    always #5 ctrl_clk = ~ctrl_clk;

    task automatic cyc();
        @(posedge ctrl_clk);
        #1;
    endtask

    task automatic accept(input logic [2:0] op, input logic [5:0] size);
        ctrl_valid_inst   = 1'b1;
        ctrl_valid_data   = 1'b1;
        ctrl_instruction  = op;
        ctrl_data_in_size = size;
        cyc();
        ctrl_valid_inst   = 1'b0;
        ctrl_valid_data   = 1'b0;
    endtask

    task automatic pulseMc();
        mc_done = 1'b1;
        cyc();
        mc_done = 1'b0;
    endtask

    task automatic pulseProc();
        procc_done = 1'b1;
        cyc();
        procc_done = 1'b0;
    endtask

    task automatic test_reset();
        ctrl_reset = 1'b1;
        repeat (2) @(posedge ctrl_clk);
        #1;
        exp = {1'b0, 1'b0, 1'b0, 1'b0, 3'b000, 6'd0};
        checks++;
        if (obs !== exp || procc_op !== 3'd0) begin
            errors++;
            $display("[TB] FAIL reset_held: got %h op %0d, want %h op 0", obs, procc_op, exp);
        end
        ctrl_reset = 1'b0;
        #1;
        checks++;
        if (ctrl_ready !== 1'b1) begin
            errors++;
            $display("[TB] FAIL reset_ready: got %b want 1", ctrl_ready);
        end
    endtask

    task automatic test_single_pass();
        accept(3'd3, 6'd5);
        exp = {1'b0, 1'b0, 1'b0, 1'b0, 3'b100, 6'd5};
        checks++;
        if (obs !== exp || procc_op !== 3'd3) begin
            errors++;
            $display("[TB] FAIL s5_store: got %h op %0d, want %h op 3", obs, procc_op, exp);
        end
        pulseMc();
        exp = {1'b0, 1'b0, 1'b0, 1'b0, 3'b010, 6'd5};
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("[TB] FAIL s5_trans: got %h want %h", obs, exp);
        end
        pulseMc();
        exp = {1'b0, 1'b0, 1'b0, 1'b1, 3'b001, 6'd5};
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("[TB] FAIL s5_proc: got %h want %h", obs, exp);
        end
        pulseProc();
        exp = {1'b1, 1'b1, 1'b0, 1'b0, 3'b000, 6'd5};
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("[TB] FAIL s5_done: got %h want %h", obs, exp);
        end
        cyc();
        exp = {1'b1, 1'b0, 1'b0, 1'b0, 3'b000, 6'd5};
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("[TB] FAIL s5_done_once: got %h want %h", obs, exp);
        end
    endtask

    task automatic test_multi_chunk();
        logic [5:0] lens [3];
        lens = '{6'd8, 6'd8, 6'd4};
        accept(3'd5, 6'd20);
        exp = {1'b0, 1'b0, 1'b0, 1'b0, 3'b100, 6'd20};
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("[TB] FAIL s20_store: got %h want %h", obs, exp);
        end
        pulseMc();
        for (int p = 0; p < 3; p++) begin
            exp = {1'b0, 1'b0, 1'b0, 1'b0, 3'b010, lens[p]};
            checks++;
            if (obs !== exp) begin
                errors++;
                $display("[TB] FAIL s20_trans%0d: got %h want %h", p, obs, exp);
            end
            pulseMc();
            exp = {1'b0, 1'b0, 1'b0, 1'b1, 3'b001, lens[p]};
            checks++;
            if (obs !== exp) begin
                errors++;
                $display("[TB] FAIL s20_proc%0d: got %h want %h", p, obs, exp);
            end
            pulseProc();
        end
        exp = {1'b1, 1'b1, 1'b0, 1'b0, 3'b000, 6'd4};
        checks++;
        if (obs !== exp || procc_op !== 3'd5) begin
            errors++;
            $display("[TB] FAIL s20_done: got %h op %0d, want %h op 5", obs, procc_op, exp);
        end
        cyc();
    endtask

    task automatic test_spurious();
        accept(3'd1, 6'd9);
        pulseMc();
        pulseProc();
        exp = {1'b0, 1'b0, 1'b0, 1'b0, 3'b010, 6'd8};
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("[TB] FAIL spur_proc_in_trans: got %h want %h", obs, exp);
        end
        pulseMc();
        pulseMc();
        exp = {1'b0, 1'b0, 1'b0, 1'b1, 3'b001, 6'd8};
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("[TB] FAIL spur_mc_in_proc: got %h want %h", obs, exp);
        end
        pulseProc();
        exp = {1'b0, 1'b0, 1'b0, 1'b0, 3'b010, 6'd1};
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("[TB] FAIL spur_tail_trans: got %h want %h", obs, exp);
        end
        pulseMc();
        pulseProc();
        exp = {1'b1, 1'b1, 1'b0, 1'b0, 3'b000, 6'd1};
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("[TB] FAIL spur_done: got %h want %h", obs, exp);
        end
        cyc();
    endtask

    task automatic test_zero_size();
        accept(3'd2, 6'd0);
        exp = {1'b1, 1'b1, 1'b0, 1'b0, 3'b000, 6'd1};
        checks++;
        if (obs !== exp || procc_op !== 3'd2) begin
            errors++;
            $display("[TB] FAIL zero_done: got %h op %0d, want %h op 2", obs, procc_op, exp);
        end
        cyc();
        exp = {1'b1, 1'b0, 1'b0, 1'b0, 3'b000, 6'd1};
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("[TB] FAIL zero_after: got %h want %h", obs, exp);
        end
    endtask

    task automatic test_reset_mid();
        accept(3'd6, 6'd20);
        pulseMc();
        pulseMc();
        #2;
        ctrl_reset = 1'b1;
        #1;
        exp = {1'b0, 1'b0, 1'b0, 1'b0, 3'b000, 6'd0};
        checks++;
        if (obs !== exp || procc_op !== 3'd0) begin
            errors++;
            $display("[TB] FAIL mid_reset: got %h op %0d, want %h op 0", obs, procc_op, exp);
        end
        cyc();
        ctrl_reset = 1'b0;
        #1;
        accept(3'd4, 6'd3);
        exp = {1'b0, 1'b0, 1'b0, 1'b0, 3'b100, 6'd3};
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("[TB] FAIL post_reset_store: got %h want %h", obs, exp);
        end
        pulseMc();
        exp = {1'b0, 1'b0, 1'b0, 1'b0, 3'b010, 6'd3};
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("[TB] FAIL post_reset_trans: got %h want %h", obs, exp);
        end
        pulseMc();
        pulseProc();
        exp = {1'b1, 1'b1, 1'b0, 1'b0, 3'b000, 6'd3};
        checks++;
        if (obs !== exp || procc_op !== 3'd4) begin
            errors++;
            $display("[TB] FAIL post_reset_done: got %h op %0d, want %h op 4", obs, procc_op, exp);
        end
        cyc();
    endtask

    task automatic test_watchdog();
        accept(3'd7, 6'd5);
`ifdef CORE_CTRL_WATCHDOG_EN
        repeat (14) cyc();
        exp = {1'b0, 1'b0, 1'b0, 1'b0, 3'b100, 6'd5};
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("[TB] FAIL wd_before_expiry: got %h want %h", obs, exp);
        end
        cyc();
        exp = {1'b0, 1'b0, 1'b1, 1'b0, 3'b000, 6'd5};
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("[TB] FAIL wd_error: got %h want %h", obs, exp);
        end
        ctrl_err_clr = 1'b1;
        cyc();
        ctrl_err_clr = 1'b0;
        exp = {1'b1, 1'b0, 1'b0, 1'b0, 3'b000, 6'd5};
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("[TB] FAIL wd_clear: got %h want %h", obs, exp);
        end
        accept(3'd7, 6'd5);
        repeat (14) cyc();
        pulseMc();
        exp = {1'b0, 1'b0, 1'b0, 1'b0, 3'b010, 6'd5};
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("[TB] FAIL wd_handshake_wins: got %h want %h", obs, exp);
        end
`else
        repeat (20) cyc();
        ctrl_err_clr = 1'b1;
        cyc();
        ctrl_err_clr = 1'b0;
        exp = {1'b0, 1'b0, 1'b0, 1'b0, 3'b100, 6'd5};
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("[TB] FAIL nowd_stall: got %h want %h", obs, exp);
        end
        pulseMc();
`endif
        pulseMc();
        pulseProc();
        exp = {1'b1, 1'b1, 1'b0, 1'b0, 3'b000, 6'd5};
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("[TB] FAIL wd_job_done: got %h want %h", obs, exp);
        end
        cyc();
    endtask

    initial begin
        ctrl_reset        = 1'b1;
        ctrl_valid_inst   = 1'b0;
        ctrl_valid_data   = 1'b0;
        ctrl_instruction  = 3'd0;
        ctrl_data_in_size = 6'd0;
        ctrl_err_clr      = 1'b0;
        mc_done           = 1'b0;
        procc_done        = 1'b0;
        test_reset();
        test_single_pass();
        test_multi_chunk();
        test_spurious();
        test_zero_size();
        test_reset_mid();
        test_watchdog();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/core_chunk_control.md
# core_chunk_control

Parametrised successor of the core control FSM. Sequences memory-controller store and transfer operations and the processing unit for one instruction. Splits a payload of up to 2^LEN_W-1 words into CHUNK-sized transfer/process passes and tracks the remaining length internally. An optional watchdog traps stalled handshakes in an ERROR state. Sits between the external instruction/data interface, the memory controller (mc_*) and the processing unit (procc_*).

## Interface
- LEN_W, 6, width of the length fields and of the remaining-word counter.
- OP_W, 3, instruction opcode width.
- CHUNK, 8, maximum words per transfer/process pass; 1 ≤ CHUNK ≤ 2^LEN_W-1.
- TO_W, 8, watchdog counter width; timeout limit is 2^TO_W-1 cycles.
- ctrl_clk  in  1  clock; all state updates on the rising edge.
- ctrl_reset  in  1  asynchronous, active-high reset.
- ctrl_valid_inst  in  1  instruction valid.
- ctrl_valid_data  in  1  input data valid.
- ctrl_instruction  in  OP_W  opcode.
- ctrl_data_in_size  in  LEN_W  payload length in words.
- ctrl_ready  out  1  block can accept an instruction.
- ctrl_done  out  1  one-cycle pulse when an instruction completes.
- ctrl_err  out  1  watchdog trap; held until ctrl_err_clr.
- ctrl_err_clr  in  1  clears ERROR.
- ctrl_data_contition  out  3  data location: 000 none, 100 input, 010 mem, 001 reg.
- mc_data_length  out  LEN_W  word count for the current MC operation.
- mc_done  in  1  MC operation complete.
- procc_start  out  1  level; processing pass active.
- procc_op  out  OP_W  latched opcode.
- procc_done  in  1  processing pass complete.

## Operation
- States: IDLE, STORE, TRANS, PROC, ERROR. All outputs are registered.
- Reset: state IDLE, remaining counter 0, watchdog counter 0, ctrl_data_contition 000, mc_data_length 0, procc_start 0, procc_op 0, ctrl_done 0, ctrl_err 0. ctrl_ready is 1 whenever state is IDLE and reset is low.
- IDLE, ctrl_valid_inst & ctrl_valid_data both high:
  - Latch procc_op and rem = size.
  - If size = 0: stay in IDLE and pulse ctrl_done the next cycle; no MC activity.
  - Otherwise: go to STORE with contition 100 and mc_data_length = size.
- STORE, mc_done: go to TRANS with contition 010 and mc_data_length = min(rem, CHUNK).
- TRANS, mc_done: go to PROC with contition 001, procc_start 1, and rem = rem - mc_data_length. rem never underflows.
- PROC, procc_done:
  - rem = 0: go to IDLE with contition 000, procc_start 0, and a one-cycle ctrl_done pulse.
  - rem ≠ 0: go to TRANS with contition 010, procc_start 0, and mc_data_length = min(rem, CHUNK).
- Ignored inputs: mc_done in IDLE, PROC and ERROR; procc_done outside PROC; valid inputs outside IDLE.
- ERROR: contition 000, procc_start 0, ctrl_err 1, ctrl_ready 0. ctrl_err_clr moves to IDLE and clears ctrl_err next cycle. rem and procc_op are not cleared.
- Reset asserted mid-operation returns every output to its reset value immediately.

## Timing
- Accept to contition 100: 1 cycle. Each handshake (mc_done or procc_done) to the next state's outputs: 1 cycle.
- A payload of N words takes ceil(N/CHUNK) TRANS→PROC passes. Example: N=20, CHUNK=8 gives mc_data_length 8, 8, 4.
- ctrl_done is high for exactly one cycle, concurrent with the return to IDLE. A new instruction can be accepted in the cycle after ctrl_done.

## Configuration
- CORE_CTRL_WATCHDOG_EN defined:
  - Watchdog counter clears on every state change and increments each cycle in STORE, TRANS and PROC.
  - On reaching 2^TO_W-1 without the expected handshake, go to ERROR.
  - If the expected handshake arrives in the same cycle as expiry, the handshake wins.
- Undefined: no counter; ERROR is unreachable; ctrl_err is tied 0; ctrl_err_clr is ignored.

## Structure
- Package core_ctrl_pkg: state enum, contition constants COND_NONE/COND_INPUT/COND_MEM/COND_REG.
- Sub-module core_ctrl_watchdog (inputs: clear, enable; output: expired), instantiated only under CORE_CTRL_WATCHDOG_EN.

## Test plan
- Size 5, CHUNK 8 -> contition 100/010/001/000; mc_data_length 5 then 5; one PROC pass; ctrl_done pulses once.
- Size 20, CHUNK 8 -> three TRANS/PROC passes with lengths 8, 8, 4; procc_start drops between passes; ctrl_done pulses after the third procc_done.
- Size 0 with both valids -> no contition change; ctrl_done pulses one cycle later; ctrl_ready stays 1.
- Spurious mc_done in PROC and procc_done in TRANS -> no state change.
- Watchdog on, TO_W 4, no mc_done in STORE -> after 15 cycles ctrl_err = 1 and contition 000; ctrl_err_clr -> IDLE and ctrl_ready = 1. Same scenario with mc_done on cycle 15 -> TRANS, no error.
- Reset asserted in PROC of a 20-word job -> all outputs at reset values immediately; a new 3-word job then completes normally.
